// File: rtl/ppu_mem_arbiter.sv
// ppu_mem_arbiter
// Shares the single address/write port of the PPU attribute, pattern and
// colour tables between buffered host writes and PPU scanline reads.
// Host writes queue in a small FIFO and drain into slots the PPU leaves free.
// During active video the PPU has priority, during vblank the host does, and
// a starvation counter forces a host slot after STARVE_MAX waiting cycles.
// Build option: define PPU_VBLANK_ONLY_EN to confine host table writes to
// vertical blanking.
module ppu_mem_arbiter #(
   parameter int FIFO_DEPTH = 8,
   parameter int STARVE_MAX = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        chipselect,
   input  logic        write,
   input  logic [11:0] address,
   input  logic [31:0] writedata,
   output logic        host_ready,
   output logic        overflow,
   input  logic        ovf_clr,
   input  logic        vblank,
   input  logic        ppu_req,
   input  logic [1:0]  ppu_sel,
   input  logic [7:0]  ppu_addr,
   output logic        ppu_grant,
   output logic        ppu_rvalid,
   output logic [2:0]  mem_we,
   output logic [7:0]  mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_rsel
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
   localparam logic [7:0]       STARVE_C = 8'(STARVE_MAX);

`ifdef PPU_VBLANK_ONLY_EN
   localparam bit VBLANK_ONLY = 1'b1;
`else
   localparam bit VBLANK_ONLY = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PPU_RD  = 2'd1,
      HOST_WR = 2'd2
   } slot_t;

   // One-hot write enable for a table select; select 3 never reaches here.
   function automatic logic [2:0] table_we(input logic [1:0] sel);
      case (sel)
         2'd0:    table_we = 3'b001;
         2'd1:    table_we = 3'b010;
         2'd2:    table_we = 3'b100;
         default: table_we = 3'b000;
      endcase
   endfunction

   logic [1:0]       fifo_sel  [FIFO_DEPTH];
   logic [7:0]       fifo_addr [FIFO_DEPTH];
   logic [31:0]      fifo_data [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [7:0]       starve_cnt;
   slot_t            state;
   slot_t            nxt_state;
   logic             vld_p1;
   logic             vld_p2;

   logic             fifo_full;
   logic             fifo_empty;
   logic             host_sel_ok;
   logic             wr_req;
   logic             push;
   logic             pop;
   logic             drop;
   logic             host_ok;
   logic             starved;
   logic [7:0]       in_addr;
   logic             unused_addr_bits;

   assign fifo_full   = (count == DEPTH_C);
   assign fifo_empty  = (count == '0);
   assign host_ready  = ~fifo_full;
   assign host_sel_ok = (address[11:10] != 2'd3);
   assign wr_req      = chipselect & write & host_sel_ok;
   assign push        = wr_req & ~fifo_full;
   assign drop        = wr_req & fifo_full;
   assign pop         = (nxt_state == HOST_WR);
   assign host_ok     = ~VBLANK_ONLY | vblank;
   assign starved     = ~fifo_empty & (starve_cnt == STARVE_C);
   // Pattern table is addressed by the full byte, attr/colour by a nibble.
   assign in_addr     = (address[11:10] == 2'd1) ? address[7:0] : {4'h0, address[3:0]};
   assign unused_addr_bits = ^address[9:8];

   assign ppu_grant   = vld_p1;
   assign ppu_rvalid  = vld_p2;

   // Pick the owner of the next memory slot from the registered count and current inputs.
   always_comb begin
      nxt_state = IDLE;
      if (starved && host_ok) begin
         nxt_state = HOST_WR;
      end else if (vblank) begin
         if (!fifo_empty && host_ok) nxt_state = HOST_WR;
         else if (ppu_req)           nxt_state = PPU_RD;
      end else begin
         if (ppu_req)                nxt_state = PPU_RD;
         else if (!fifo_empty && host_ok) nxt_state = HOST_WR;
      end
   end

   // FIFO storage: payload only, pointers live with the control state.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_sel[wr_ptr]  <= address[11:10];
         fifo_addr[wr_ptr] <= in_addr;
         fifo_data[wr_ptr] <= writedata;
      end
   end

   // FIFO pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         overflow <= drop | (overflow & ~ovf_clr);
      end
   end

   // Slot FSM with registered memory-port outputs and starvation tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         vld_p1     <= 1'b0;
         vld_p2     <= 1'b0;
         mem_we     <= 3'b000;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_rsel   <= '0;
         starve_cnt <= '0;
      end else begin
         state  <= nxt_state;
         // read data is valid one cycle after the granted slot
         vld_p2 <= (state == PPU_RD);
         case (nxt_state)
            HOST_WR: begin
               vld_p1    <= 1'b0;
               mem_we    <= table_we(fifo_sel[rd_ptr]);
               mem_addr  <= fifo_addr[rd_ptr];
               mem_wdata <= fifo_data[rd_ptr];
            end
            PPU_RD: begin
               vld_p1   <= 1'b1;
               mem_we   <= 3'b000;
               mem_addr <= ppu_addr;
               mem_rsel <= ppu_sel;
            end
            default: begin
               vld_p1 <= 1'b0;
               mem_we <= 3'b000;
            end
         endcase
         if (fifo_empty || nxt_state == HOST_WR || !host_ok)
            starve_cnt <= '0;
         else if (starve_cnt != STARVE_C)
            starve_cnt <= starve_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// tb_ppu_mem_arbiter
// Directed scenarios followed by randomized traffic, checked against a
// queue-based reference model of the arbiter.
module tb_ppu_mem_arbiter;

   localparam int FIFO_DEPTH = 8;
   localparam int STARVE_MAX = 64;

   logic        clk = 1'b0;
   logic        reset;
   logic        chipselect, write, ovf_clr, vblank, ppu_req;
   logic [11:0] address;
   logic [31:0] writedata;
   logic [1:0]  ppu_sel;
   logic [7:0]  ppu_addr;
   logic        host_ready, overflow, ppu_grant, ppu_rvalid;
   logic [2:0]  mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [1:0]  mem_rsel;

   always #5 clk = ~clk;

   ppu_mem_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
      .address(address), .writedata(writedata), .host_ready(host_ready),
      .overflow(overflow), .ovf_clr(ovf_clr), .vblank(vblank), .ppu_req(ppu_req),
      .ppu_sel(ppu_sel), .ppu_addr(ppu_addr), .ppu_grant(ppu_grant),
      .ppu_rvalid(ppu_rvalid), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rsel(mem_rsel)
   );

   typedef struct {
      logic [1:0]  sel;
      logic [7:0]  addr;
      logic [31:0] data;
   } entry_t;

   entry_t      q[$];
   int          starve;
   int          slot;          // 0 idle, 1 PPU read, 2 host write
   int          cyc;
   int          host_at[$];
   logic        exp_grant, exp_rvalid, exp_ovf;
   logic [2:0]  exp_we;
   logic [7:0]  exp_addr;
   logic [31:0] exp_wdata;
   logic [1:0]  exp_rsel;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One clock: predict from the inputs present before the edge, then compare.
   task automatic cycle();
      int     n;
      bit     host_ok, wr;
      entry_t e;
      n = q.size();
`ifdef PPU_VBLANK_ONLY_EN
      host_ok = vblank;
`else
      host_ok = 1'b1;
`endif
      exp_rvalid = exp_grant;
      if (n > 0 && starve == STARVE_MAX && host_ok) slot = 2;
      else if (vblank) slot = (n > 0 && host_ok) ? 2 : (ppu_req ? 1 : 0);
      else slot = ppu_req ? 1 : ((n > 0 && host_ok) ? 2 : 0);
      exp_grant = (slot == 1);
      exp_we = 3'b000;
      if (slot == 2) begin
         e = q.pop_front();
         exp_we = 3'b001 << e.sel;
         exp_addr = e.addr;
         exp_wdata = e.data;
      end
      if (slot == 1) begin
         exp_addr = ppu_addr;
         exp_rsel = ppu_sel;
      end
      if (n == 0 || slot == 2 || !host_ok) starve = 0;
      else if (starve < STARVE_MAX) starve = starve + 1;
      wr = chipselect && write && (address[11:10] != 2'd3);
      if (wr && n < FIFO_DEPTH) begin
         e.sel = address[11:10];
         e.addr = (address[11:10] == 2'd1) ? address[7:0] : {4'h0, address[3:0]};
         e.data = writedata;
         q.push_back(e);
      end
      if (wr && n == FIFO_DEPTH) exp_ovf = 1'b1;
      else if (ovf_clr) exp_ovf = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (slot == 2) host_at.push_back(cyc);
      chk("ppu_grant", ppu_grant, exp_grant);
      chk("ppu_rvalid", ppu_rvalid, exp_rvalid);
      chk("mem_we", mem_we, exp_we);
      chk("host_ready", host_ready, q.size() < FIFO_DEPTH);
      chk("overflow", overflow, exp_ovf);
      if (slot == 1) begin
         chk("rd_addr", mem_addr, exp_addr);
         chk("rd_rsel", mem_rsel, exp_rsel);
      end
      if (slot == 2) begin
         chk("wr_addr", mem_addr, exp_addr);
         chk("wr_wdata", mem_wdata, exp_wdata);
      end
   endtask

   task automatic hw(input logic [11:0] a, input logic [31:0] d);
      chipselect = 1'b1;
      write = 1'b1;
      address = a;
      writedata = d;
      cycle();
      chipselect = 1'b0;
      write = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      q.delete();
      starve = 0;
      exp_grant = 1'b0; exp_rvalid = 1'b0; exp_ovf = 1'b0;
      exp_we = 3'b000; exp_addr = 8'h00; exp_wdata = 32'h0; exp_rsel = 2'd0;
      chk("rst_mem_we", mem_we, 3'b000);
      chk("rst_grant", ppu_grant, 1'b0);
      chk("rst_rvalid", ppu_rvalid, 1'b0);
      chk("rst_mem_addr", mem_addr, 8'h00);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_rsel", mem_rsel, 2'd0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_host_ready", host_ready, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      chipselect = 1'b0; write = 1'b0; address = '0; writedata = '0;
      ovf_clr = 1'b0; vblank = 1'b0; ppu_req = 1'b0; ppu_sel = 2'd0; ppu_addr = 8'h00;
      cyc = 0;
      do_reset();

      // single write into the pattern table while idle
      hw(12'h405, 32'hDEADBEEF);
      cycle();
      chk("t1_we", mem_we, 3'b010);
      chk("t1_addr", mem_addr, 8'h05);
      chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
      cycle();
      chk("t1_we_after", mem_we, 3'b000);

      // continuous PPU demand: host only progresses through starvation slots
      ppu_req = 1'b1; ppu_sel = 2'd1; ppu_addr = 8'h3C;
      host_at.delete();
      hw(12'h801, 32'h1111_0001);
      hw(12'h802, 32'h2222_0002);
      hw(12'h803, 32'h3333_0003);
      repeat (200) cycle();
      chk("t2_host_slots", host_at.size(), 3);
      if (host_at.size() == 3) begin
         chk("t2_gap0", host_at[1] - host_at[0], STARVE_MAX + 1);
         chk("t2_gap1", host_at[2] - host_at[1], STARVE_MAX + 1);
      end

      // fill the FIFO and overflow it
      for (int i = 0; i < 9; i++) begin
         hw(12'h000 + 12'(i), 32'hA000_0000 + 32'(i));
         if (i == 7) chk("t3_ready_full", host_ready, 1'b0);
      end
      chk("t3_ovf_set", overflow, 1'b1);
      ovf_clr = 1'b1;
      hw(12'h00F, 32'hBAD0_0000);
      chk("t3_set_wins", overflow, 1'b1);
      cycle();
      ovf_clr = 1'b0;
      chk("t3_ovf_clr", overflow, 1'b0);
      vblank = 1'b1;
      repeat (12) cycle();
      vblank = 1'b0;

      // vblank gives queued host writes priority over a pending PPU read
      hw(12'h003, 32'hCAFE_0003);
      hw(12'h4AB, 32'hCAFE_04AB);
      vblank = 1'b1;
      cycle();
      chk("t4_first_we", mem_we, 3'b001);
      chk("t4_first_grant", ppu_grant, 1'b0);
      cycle();
      chk("t4_second_we", mem_we, 3'b010);
      chk("t4_second_addr", mem_addr, 8'hAB);
      cycle();
      chk("t4_grant", ppu_grant, 1'b1);
      cycle();
      chk("t4_rvalid", ppu_rvalid, 1'b1);
      vblank = 1'b0; ppu_req = 1'b0;
      cycle();

      // reserved table select is ignored
      hw(12'hC00, 32'h5555_AAAA);
      chk("t5_ready", host_ready, 1'b1);
      chk("t5_ovf", overflow, 1'b0);
      cycle();
      chk("t5_no_we", mem_we, 3'b000);

      // reset while writes are pending discards them
      ppu_req = 1'b1;
      for (int i = 0; i < 4; i++) hw(12'h800 + 12'(i), 32'hEE00_0000 + 32'(i));
      vblank = 1'b1;
      cycle();
      chk("t6_we_before", mem_we, 3'b100);
      do_reset();
      ppu_req = 1'b0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         chk("t6_no_stale", mem_we, 3'b000);
      end
      chk("t6_ready", host_ready, 1'b1);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         chipselect = ($urandom_range(3) != 0);
         write = ($urandom_range(1) == 1);
         address = 12'($urandom);
         writedata = $urandom;
         ovf_clr = ($urandom_range(15) == 0);
         if ($urandom_range(39) == 0) vblank = ~vblank;
         ppu_req = ($urandom_range(9) < 7);
         ppu_sel = 2'($urandom);
         ppu_addr = 8'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
